// File: rtl/multicycle_control_32.sv
// multicycle_control_32: main control FSM for the multicycle 32-bit MIPS datapath.
// A Moore machine steps each instruction through fetch, decode, execute, memory
// and write-back. It waits in FETCH, MEM_RD and MEM_WR until memory is ready.
//
// Ports:
//   clk, rst_n          rising-edge clock; synchronous active-low reset
//   opcode, func        instruction fields [31:26] and [5:0]
//   mem_ready           memory completes the current access this cycle
//   pc_write .. alu_src_a  single-bit datapath strobes and mux selects
//   alu_src_b           00 B, 01 const 4, 10 sext imm, 11 sext imm << 2
//   pc_source           00 ALU result, 01 ALUOut, 10 jump target, 11 rs
//   alu_op              00 add, 01 sub, 10 use func
//   err_illegal_opcode  sticky; set by an unsupported opcode in DECODE
//   state               current state code, for debug
//
// Build option: define MULTICYCLE_ADDI_EN to support addi (states 12-13).
module multicycle_control_32 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       err_illegal_opcode,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_RD    = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WR    = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_JR        = 4'd11
`ifdef MULTICYCLE_ADDI_EN
    ,
    ST_ADDI_EXEC = 4'd12,
    ST_ADDI_WB   = 4'd13
`endif
  } state_t;

  state_t state_q, state_d;
  logic   err_q, err_d;

  // State and sticky error register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next-state and Moore output decode (FETCH strobes also gated by mem_ready)
  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 2'b00;

    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_RTYPE:     state_d = (func == FN_JR) ? ST_JR : ST_R_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      state_d = ST_ADDI_EXEC;
`endif
          default: begin
            err_d   = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Only lw and sw reach here, and opcode is held stable since DECODE
        state_d   = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ST_R_WB;
      end
      ST_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = ST_FETCH;
      end
      ST_JR: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
        state_d   = ST_FETCH;
      end
`ifdef MULTICYCLE_ADDI_EN
      ST_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
`endif
      // Unused codes recover to FETCH
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign err_illegal_opcode = err_q;
  assign state              = state_q;

endmodule

// File: tb/tb_multicycle_control_32.sv
// Self-checking bench for multicycle_control_32: a per-cycle vector table
// followed by hand-written sequences for addi and the sticky error flag.
module tb_multicycle_control_32;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic       err_illegal_opcode;
  logic [3:0] state;

  multicycle_control_32 dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .opcode             (opcode),
    .func               (func),
    .mem_ready          (mem_ready),
    .pc_write           (pc_write),
    .pc_write_cond      (pc_write_cond),
    .i_or_d             (i_or_d),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .ir_write           (ir_write),
    .mem_to_reg         (mem_to_reg),
    .reg_dst            (reg_dst),
    .reg_write          (reg_write),
    .alu_src_a          (alu_src_a),
    .alu_src_b          (alu_src_b),
    .pc_source          (pc_source),
    .alu_op             (alu_op),
    .err_illegal_opcode (err_illegal_opcode),
    .state              (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word layout:
  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a}_alu_src_b_pc_source_alu_op_err
  localparam logic [16:0] O_NONE   = 17'b0000000000_00_00_00_0;
  localparam logic [16:0] O_FRDY   = 17'b1001010000_01_00_00_0;
  localparam logic [16:0] O_FWAIT  = 17'b0001000000_01_00_00_0;
  localparam logic [16:0] O_DEC    = 17'b0000000000_11_00_00_0;
  localparam logic [16:0] O_MADDR  = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] O_MRD    = 17'b0011000000_00_00_00_0;
  localparam logic [16:0] O_MWB    = 17'b0000001010_00_00_00_0;
  localparam logic [16:0] O_MWR    = 17'b0010100000_00_00_00_0;
  localparam logic [16:0] O_REX    = 17'b0000000001_00_00_10_0;
  localparam logic [16:0] O_RWB    = 17'b0000000110_00_00_00_0;
  localparam logic [16:0] O_BR     = 17'b0100000001_00_01_01_0;
  localparam logic [16:0] O_J      = 17'b1000000000_00_10_00_0;
  localparam logic [16:0] O_JR     = 17'b1000000000_00_11_00_0;
`ifdef MULTICYCLE_ADDI_EN
  localparam logic [16:0] O_AEX    = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] O_AWB    = 17'b0000000010_00_00_00_0;
`endif

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_JR = 6'b001000;

  typedef struct {
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       mem_ready;
    logic [3:0] exp_state;
    logic [16:0] exp_out;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_pass;

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input logic [3:0] st, input logic [16:0] o,
                     input logic err);
    vec_t v;
    v.rst_n = r; v.opcode = op; v.func = fn; v.mem_ready = rdy;
    v.exp_state = st; v.exp_out = o | 17'(err);
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy);
    @(negedge clk);
    rst_n = r; opcode = op; func = fn; mem_ready = rdy;
    #1;
  endtask

  task automatic check(input string tag, input int idx, input logic [3:0] exp_st,
                       input logic [16:0] exp_o);
    logic [16:0] act;
    act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_op, err_illegal_opcode};
    n_checks++;
    if (state !== exp_st)
      $display("FAIL %s[%0d] state: got %0d, expected %0d", tag, idx, state, exp_st);
    else
      n_pass++;
    n_checks++;
    if (act !== exp_o)
      $display("FAIL %s[%0d] outputs (state %0d): got %b, expected %b",
               tag, idx, state, act, exp_o);
    else
      n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0; opcode = 6'd0; func = 6'd0; mem_ready = 1'b0;

    // Reset held two cycles, then released
    add(0, RT,  F_ADD, 0, 4'd0,  O_NONE,  0);
    add(1, RT,  F_ADD, 0, 4'd0,  O_NONE,  0);
    // lw, no waits: 1 2 3 4 5
    add(1, LW,  F_ADD, 1, 4'd1,  O_FRDY,  0);
    add(1, LW,  F_ADD, 1, 4'd2,  O_DEC,   0);
    add(1, LW,  F_ADD, 1, 4'd3,  O_MADDR, 0);
    add(1, LW,  F_ADD, 1, 4'd4,  O_MRD,   0);
    add(1, LW,  F_ADD, 1, 4'd5,  O_MWB,   0);
    // R-type add, mem_ready low where it is ignored
    add(1, RT,  F_ADD, 1, 4'd1,  O_FRDY,  0);
    add(1, RT,  F_ADD, 1, 4'd2,  O_DEC,   0);
    add(1, RT,  F_ADD, 0, 4'd7,  O_REX,   0);
    add(1, RT,  F_ADD, 0, 4'd8,  O_RWB,   0);
    // jr
    add(1, RT,  F_JR,  1, 4'd1,  O_FRDY,  0);
    add(1, RT,  F_JR,  1, 4'd2,  O_DEC,   0);
    add(1, RT,  F_JR,  1, 4'd11, O_JR,    0);
    // beq
    add(1, BEQ, F_JR,  1, 4'd1,  O_FRDY,  0);
    add(1, BEQ, F_JR,  1, 4'd2,  O_DEC,   0);
    add(1, BEQ, F_JR,  1, 4'd9,  O_BR,    0);
    // j
    add(1, JMP, F_ADD, 1, 4'd1,  O_FRDY,  0);
    add(1, JMP, F_ADD, 1, 4'd2,  O_DEC,   0);
    add(1, JMP, F_ADD, 1, 4'd10, O_J,     0);
    // sw with three wait cycles in MEM_WR
    add(1, SW,  F_ADD, 1, 4'd1,  O_FRDY,  0);
    add(1, SW,  F_ADD, 0, 4'd2,  O_DEC,   0);
    add(1, SW,  F_ADD, 0, 4'd3,  O_MADDR, 0);
    add(1, SW,  F_ADD, 0, 4'd6,  O_MWR,   0);
    add(1, SW,  F_ADD, 0, 4'd6,  O_MWR,   0);
    add(1, SW,  F_ADD, 0, 4'd6,  O_MWR,   0);
    add(1, SW,  F_ADD, 1, 4'd6,  O_MWR,   0);
    // FETCH with two wait cycles, then an illegal opcode
    add(1, BAD, F_ADD, 0, 4'd1,  O_FWAIT, 0);
    add(1, BAD, F_ADD, 0, 4'd1,  O_FWAIT, 0);
    add(1, BAD, F_ADD, 1, 4'd1,  O_FRDY,  0);
    add(1, BAD, F_ADD, 1, 4'd2,  O_DEC,   0);
    // Flag now set; lw stalls in MEM_RD and is reset mid-access
    add(1, LW,  F_ADD, 1, 4'd1,  O_FRDY,  1);
    add(1, LW,  F_ADD, 1, 4'd2,  O_DEC,   1);
    add(1, LW,  F_ADD, 1, 4'd3,  O_MADDR, 1);
    add(1, LW,  F_ADD, 0, 4'd4,  O_MRD,   1);
    add(0, LW,  F_ADD, 0, 4'd4,  O_MRD,   1);
    add(1, ADDI, F_ADD, 1, 4'd0, O_NONE,  0);
    add(1, ADDI, F_ADD, 1, 4'd1, O_FRDY,  0);

    @(posedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].opcode, vecs[i].func, vecs[i].mem_ready);
      check("vec", i, vecs[i].exp_state, vecs[i].exp_out);
    end

    // addi decode, continuing from the FETCH above
    drive(1, ADDI, F_ADD, 1);
    check("addi", 0, 4'd2, O_DEC);
`ifdef MULTICYCLE_ADDI_EN
    drive(1, ADDI, F_ADD, 1);
    check("addi", 1, 4'd12, O_AEX);
    drive(1, ADDI, F_ADD, 1);
    check("addi", 2, 4'd13, O_AWB);
    drive(1, ADDI, F_ADD, 1);
    check("addi", 3, 4'd1, O_FRDY);
`else
    drive(1, ADDI, F_ADD, 1);
    check("addi", 1, 4'd1, O_FRDY | 17'd1);
`endif

    // Sticky flag: reset, illegal opcode, then ten cycles of j instructions
    drive(0, BAD, F_ADD, 1);
    drive(1, BAD, F_ADD, 1);
    check("sticky", 0, 4'd0, O_NONE);
    drive(1, BAD, F_ADD, 1);
    check("sticky", 1, 4'd1, O_FRDY);
    drive(1, BAD, F_ADD, 1);
    check("sticky", 2, 4'd2, O_DEC);
    for (int k = 0; k < 10; k++) begin
      drive(1, JMP, F_ADD, 1);
      case (k % 3)
        0:       check("sticky", 3 + k, 4'd1,  O_FRDY | 17'd1);
        1:       check("sticky", 3 + k, 4'd2,  O_DEC  | 17'd1);
        default: check("sticky", 3 + k, 4'd10, O_J    | 17'd1);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
